ysyx_23060203_mdu: RTL and testbench
====================================

# ysyx_23060203_mdu

Parametrised iterative multiply/divide unit for the RV32M/RV64M instructions in the EXU execute stage. It replaces the separate fixed-width multiply and divide test units with one block. It takes operands and funct3 over a valid/ready handshake and produces the selected XLEN-bit result over a second handshake. It honours the pipeline `flush`, can process several multiplier bits per cycle, and resolves divide-by-zero and signed overflow in one cycle.

## Interface
- `XLEN`, 32, operand/result width; must be 32 or 64.
- `MUL_BITS`, 2, multiplier bits retired per MUL cycle; must be 1, 2 or 4 and divide `XLEN`.
- `clock` in 1, clock.
- `reset` in 1, reset: synchronous, active-high.
- `flush` in 1, kill the in-flight op; wins over every other event.
- `in_valid` in 1, operation offered.
- `in_ready` out 1, unit can accept an operation.
- `in_funct` in 3, RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_a`, `in_b` in XLEN, rs1 and rs2 values.
- `out_valid` out 1, result available.
- `out_ready` in 1, consumer takes the result.
- `out_val` out XLEN, selected result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset values: state IDLE, `out_valid` 0, `out_val` 0, `in_ready` 1, counter 0.
- Accept condition: `in_valid & in_ready & ~flush`. On accept, the unit latches funct and operand magnitudes, plus sign flags.
- Signedness:
  - `a` is signed for funct 1, 2, 4, 6.
  - `b` is signed for funct 1, 4, 6.
- Magnitude of a signed negative operand: two's-complement negation. The XLEN-bit unsigned result is exact for the most negative value.
- IDLE → MUL on accept with funct[2]=0. The counter loads `XLEN/MUL_BITS`.
- MUL step: add `mag_a × b_bits[MUL_BITS-1:0]` into the upper half of a 2·XLEN accumulator, shift right by `MUL_BITS`, decrement. When the counter reaches 0: negate the product if the signs differ, then go to DONE.
- IDLE → DIV on accept with funct[2]=1 and a normal case. Division is radix-2 restoring, one quotient bit per cycle, with the counter loaded to XLEN. At the end:
  - quotient sign = `sa ^ sb`;
  - remainder sign = `sa`.
- IDLE → DONE directly for the special cases, which take no iterations:
  - divide by zero: quotient all ones, remainder = `in_a`;
  - signed overflow (`a` = most negative, `b` = −1, funct 4 or 6): quotient = `in_a`, remainder 0.
- Result selection:
  - MUL: low half of the product;
  - MULH, MULHSU, MULHU: high half;
  - DIV, DIVU: quotient;
  - REM, REMU: remainder.
- The result is registered into `out_val` on entry to DONE.
- DONE → IDLE on `out_ready`. If `in_valid` is high in the same cycle, the unit accepts directly into the next operation (back-to-back).
- `flush`: in any state, the next state is IDLE and the counter is cleared. `out_val` holds its old value and is don't-care.

## Timing
- `in_ready = ~flush & (state==IDLE | (state==DONE & out_ready))`.
- `out_valid = ~flush & (state==DONE)`. The flush gating is combinational; a result is never delivered in a flush cycle.
- Latency, counted from accept edge to the first `out_valid` cycle:
  - MUL group: `XLEN/MUL_BITS + 1` cycles;
  - DIV group: `XLEN + 1` cycles;
  - special cases: 1 cycle.
- Throughput: one op per latency; there is no bubble when `out_ready` is held high.
- `out_val` and `out_valid` stay stable while `out_valid & ~out_ready`.
- Reset mid-operation behaves identically to flush, and in addition clears `out_val` to 0.
- `flush` together with `in_valid`: the op is not accepted.

## Structure
- Shared package `ysyx_23060203_pkg` holds:
  - funct3 constants `MDU_MUL` … `MDU_REMU`;
  - state enum `mdu_state_t`.
- Counter width: `$clog2(XLEN+1)`.
- Sub-module `ysyx_23060203_mdu_sign` handles operand magnitude and conditional final negation, parametrised by width, and is instantiated for operands and results.
- Everything else stays in one module.
- The EXU instantiates this block with its pipeline `flush` connected, in place of the hard-wired 0.

## Test plan
All cases use XLEN=32, MUL_BITS=2.
- MULH, a=0xFFFFFFFE, b=3 → out_val 0xFFFFFFFF, first `out_valid` 17 cycles after accept. The same operands with MUL → 0xFFFFFFFA.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- DIV, a=−7, b=2 → 0xFFFFFFFD (−3), after 33 cycles. REM with the same operands → 0xFFFFFFFF (−1). REMU, 7 % 0x10 → 7.
- DIVU by 0, a=5 → 0xFFFFFFFF, 1-cycle latency. REM, a=0x80000000, b=−1 → 0, 1-cycle latency. DIV with the same operands → 0x80000000.
- Flush at cycle 10 of a DIV → `out_valid` stays 0. `in_ready` is 1 on the next cycle. A new MUL 3×4 then returns 12.
- Backpressure: hold `out_ready` low for 5 cycles in DONE → `out_val` is stable and `in_ready` is 0. Then raise `out_ready` with a new `in_valid` in the same cycle → back-to-back accept, and both results are correct.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Shared definitions for the multiply/divide unit:
// RISC-V M-extension funct3 codes and the MDU state encoding.
package ysyx_23060203_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/ysyx_23060203_mdu_sign.sv
// Conditional two's-complement negation of a W-bit value.
// Ports: val (in), neg (in, negate when 1), res (out).
module ysyx_23060203_mdu_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ysyx_23060203_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Ports: clock, reset (sync, high), flush, in_valid/in_ready/in_funct/in_a/in_b,
//        out_valid/out_ready/out_val.
module ysyx_23060203_mdu
    import ysyx_23060203_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_val
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int XM = XLEN + MUL_BITS;
    localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] DIV_CNT = CW'(XLEN);

    mdu_state_t state, state_n, start_st;

    logic [CW-1:0]     cnt;
    logic [2:0]        funct;
    logic              sa, sb;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, acc_nx;

    logic            accept, a_sgn, b_sgn, sa_in, sb_in;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;

    assign in_ready  = ~flush & ((state == IDLE) |
                                 ((state == DONE) & out_ready));
    assign out_valid = ~flush & (state == DONE);
    assign accept    = in_valid & in_ready;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (in_funct)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            MDU_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign sa_in = a_sgn & in_a[XLEN-1];
    assign sb_in = b_sgn & in_b[XLEN-1];

    ysyx_23060203_mdu_sign #(.W(XLEN)) u_mag_a (
        .val(in_a), .neg(sa_in), .res(mag_a)
    );
    ysyx_23060203_mdu_sign #(.W(XLEN)) u_mag_b (
        .val(in_b), .neg(sb_in), .res(mag_b)
    );

    // Special divides finish at accept without iterating.
    assign div_zero = (in_b == '0);
    assign ovf      = a_sgn & b_sgn & (&in_b) &
                      (in_a == {1'b1, {(XLEN-1){1'b0}}});
    assign special  = in_funct[2] & (div_zero | ovf);

    always_comb begin
        if (div_zero) spec_val = in_funct[1] ? in_a : '1;
        else          spec_val = in_funct[1] ? '0 : in_a;
    end

    always_comb begin
        if (special)          start_st = DONE;
        else if (in_funct[2]) start_st = DIV;
        else                  start_st = MUL;
    end

    // MUL: upper half accumulates, lower half holds shifting multiplier.
    logic [XM-1:0] mul_sum;
    assign mul_sum = XM'(acc[2*XLEN-1:XLEN]) +
                     XM'(opnd) * XM'(acc[MUL_BITS-1:0]);

    // DIV: upper half is partial remainder, lower half dividend/quotient.
    logic [XLEN:0] div_sh, div_df;
    assign div_sh = acc[2*XLEN-1:XLEN-1];
    assign div_df = div_sh - {1'b0, opnd};

    always_comb begin
        if (state == MUL)
            acc_nx = {mul_sum, acc[XLEN-1:MUL_BITS]};
        else if (div_df[XLEN])
            acc_nx = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_nx = {div_df[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quot_f, rem_f, fin_val;

    ysyx_23060203_mdu_sign #(.W(2*XLEN)) u_neg_p (
        .val(acc_nx), .neg(sa ^ sb), .res(prod_f)
    );
    ysyx_23060203_mdu_sign #(.W(XLEN)) u_neg_q (
        .val(acc_nx[XLEN-1:0]), .neg(sa ^ sb), .res(quot_f)
    );
    ysyx_23060203_mdu_sign #(.W(XLEN)) u_neg_r (
        .val(acc_nx[2*XLEN-1:XLEN]), .neg(sa), .res(rem_f)
    );

    always_comb begin
        unique case (1'b1)
            funct[2] & funct[1]:  fin_val = rem_f;
            funct[2] & ~funct[1]: fin_val = quot_f;
            ~funct[2] & (funct[1:0] == 2'b00):
                fin_val = prod_f[XLEN-1:0];
            default: fin_val = prod_f[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = start_st;
            MUL, DIV: if (cnt == CW'(1)) state_n = DONE;
            DONE: begin
                if (accept)         state_n = start_st;
                else if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            funct   <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            out_val <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            funct <= in_funct;
            sa    <= sa_in;
            sb    <= sb_in;
            if (special) begin
                cnt     <= '0;
                out_val <= spec_val;
            end else if (in_funct[2]) begin
                cnt  <= DIV_CNT;
                opnd <= mag_b;
                acc  <= {{XLEN{1'b0}}, mag_a};
            end else begin
                cnt  <= MUL_CNT;
                opnd <= mag_a;
                acc  <= {{XLEN{1'b0}}, mag_b};
            end
        end else if ((state == MUL) || (state == DIV)) begin
            acc <= acc_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) out_val <= fin_val;
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_mdu.sv
// Directed bench for ysyx_23060203_mdu (XLEN=32, MUL_BITS=2):
// vector table plus flush, reset and backpressure sequences.
module tb_ysyx_23060203_mdu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_val;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ysyx_23060203_mdu #(.XLEN(32), .MUL_BITS(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_funct (in_funct),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_val  (out_val)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          l;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        in_funct = f;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1 lat++;
        end
    endtask

    task automatic consume();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    task automatic do_op(input string n, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int l);
        int lat;
        issue(f, a, b);
        wait_valid(lat);
        chk({n, " val"}, out_val, e);
        chk({n, " lat"}, 32'(lat), 32'(l));
        consume();
    endtask

    initial begin
        int lat;
        logic seen;

        vecs = '{
            '{3'd1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 17},
            '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 17},
            '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17},
            '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17},
            '{3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33},
            '{3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33},
            '{3'd7, 32'h7,        32'h10,       32'h7,        33},
            '{3'd5, 32'h5,        32'h0,        32'hFFFFFFFF, 1},
            '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1},
            '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
            '{3'd6, 32'h7,        32'h0,        32'h7,        1},
            '{3'd7, 32'h1234,     32'h0,        32'h1234,     1},
            '{3'd4, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33},
            '{3'd6, 32'h7,        32'hFFFFFFFE, 32'h1,        33},
            '{3'd5, 32'd100,      32'd7,        32'd14,       33},
            '{3'd4, 32'h80000000, 32'h1,        32'h80000000, 33},
            '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h0,        33},
            '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 17},
            '{3'd3, 32'h00010000, 32'h00010000, 32'h1,        17},
            '{3'd0, 32'h00010000, 32'h00010000, 32'h0,        17}
        };

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_val", out_val, 32'd0);

        for (int i = 0; i < NV; i++)
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a,
                  vecs[i].b, vecs[i].e, vecs[i].l);

        // Flush during the 10th cycle of a divide.
        issue(3'd5, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1;
        chk("flush in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        flush = 1'b0;
        #1;
        chk("post-flush in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("flush no result", {31'd0, seen}, 32'd0);
        do_op("mul 3x4", 3'd0, 32'd3, 32'd4, 32'd12, 17);

        // Reset in the middle of a multiply.
        issue(3'd0, 32'd5, 32'd6);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset out_val", out_val, 32'd0);
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clock);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("midreset no result", {31'd0, seen}, 32'd0);

        // Backpressure then back-to-back accept.
        issue(3'd5, 32'd100, 32'd7);
        wait_valid(lat);
        chk("bp lat", 32'(lat), 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("bp%0d val", k), out_val, 32'd14);
            chk($sformatf("bp%0d valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        in_funct  = 3'd0;
        in_a      = 32'd3;
        in_b      = 32'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
        chk("b2b first val", out_val, 32'd14);
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b busy", {31'd0, out_valid}, 32'd0);
        wait_valid(lat);
        chk("b2b lat", 32'(lat), 32'd17);
        chk("b2b second val", out_val, 32'd15);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
